// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings and
// iteration count, plus small decode helpers used at operation launch.
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULT  = 2'd0,
        MD_OP_MULTU = 2'd1,
        MD_OP_DIV   = 2'd2,
        MD_OP_DIVU  = 2'd3
    } md_op_e;

    localparam int unsigned MD_ITER = 32;

    function automatic logic op_is_div(input md_op_e op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input md_op_e op);
        return (op == MD_OP_MULT) || (op == MD_OP_DIV);
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit owning the architectural HI/LO pair.
// Magnitudes are iterated for 32 cycles; signs are applied in a final fix-up cycle.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

    state_e      state, state_next;
    md_op_e      op_in, op_q;
    logic [5:0]  iter;
    logic        neg_q, rneg_q, zero_q;
    logic [31:0] raw_a, opnd;
    logic [63:0] work, work_next;
    logic [31:0] hi_q, lo_q, res_hi, res_lo;
    logic        done_q, in_signed;
    logic [32:0] mul_sum, div_shift, div_diff;

    assign op_in     = md_op_e'(md_op);
    assign in_signed = op_is_signed(op_in);
    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (iter == 6'(MD_ITER - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Multiply keeps {partial product, multiplier} in work; divide keeps
    // {remainder, dividend/quotient}. opnd is the multiplicand or divisor.
    always_comb begin
        mul_sum   = {1'b0, work[63:32]} + (work[0] ? {1'b0, opnd} : 33'd0);
        div_shift = work[63:31];
        div_diff  = div_shift - {1'b0, opnd};
        if (!op_is_div(op_q))
            work_next = {mul_sum, work[31:1]};
        else if (div_diff[32])
            work_next = {div_shift[31:0], work[30:0], 1'b0};
        else
            work_next = {div_diff[31:0], work[30:0], 1'b1};
    end

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        if (!op_is_div(op_q)) begin
            {res_hi, res_lo} = neg_q ? -work : work;
        end else if (zero_q) begin
            res_lo = '1;
            res_hi = raw_a;
        end else begin
            res_lo = neg_q  ? -work[31:0]  : work[31:0];
            res_hi = rneg_q ? -work[63:32] : work[63:32];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= MD_OP_MULT;
            iter   <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            zero_q <= 1'b0;
            raw_a  <= '0;
            opnd   <= '0;
            work   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (mthi) hi_q <= wdata;
                    if (mtlo) lo_q <= wdata;
                    if (start) begin
                        op_q   <= op_in;
                        iter   <= '0;
                        neg_q  <= in_signed & (SrcA[31] ^ SrcB[31]);
                        rneg_q <= in_signed & SrcA[31];
                        zero_q <= (SrcB == 32'd0);
                        raw_a  <= SrcA;
                        if (op_is_div(op_in)) begin
                            opnd <= in_signed ? abs32(SrcB) : SrcB;
                            work <= {32'd0, (in_signed ? abs32(SrcA) : SrcA)};
                        end else begin
                            opnd <= in_signed ? abs32(SrcA) : SrcA;
                            work <= {32'd0, (in_signed ? abs32(SrcB) : SrcB)};
                        end
                    end
                end
                CALC: begin
                    work <= work_next;
                    iter <= iter + 6'd1;
                end
                FIX: begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver queues reference results,
// an independent monitor compares HI/LO whenever done pulses.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  md_op = 2'd0;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    localparam logic [1:0] OP_MULT = 2'd0, OP_MULTU = 2'd1, OP_DIV = 2'd2, OP_DIVU = 2'd3;

    int checks = 0;
    int errors = 0;
    int busy_cycles = 0;
    logic [63:0] exp_q[$];

    muldiv_unit dut (
        .clk(clk), .rst(rst), .start(start), .md_op(md_op),
        .SrcA(SrcA), .SrcB(SrcB), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MULT:  p = 64'(sa * sb);
            OP_MULTU: p = {32'd0, a} * {32'd0, b};
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else if (op == OP_DIV) begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin : monitor
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst) busy_cycles = 0;
            else begin
                if (busy) busy_cycles++;
                if (done) begin
                    check("done_while_busy", 64'(busy), 64'd0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done with hi=%h lo=%h expected no done", hi, lo);
                    end else begin
                        e = exp_q.pop_front();
                        check("result_hi", 64'(hi), 64'(e[63:32]));
                        check("result_lo", 64'(lo), 64'(e[31:0]));
                        check("busy_cycles", 64'(busy_cycles), 64'd33);
                    end
                    busy_cycles = 0;
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
        @(posedge clk); #1;
        start = 1'b1; md_op = op; SrcA = a; SrcB = b;
        if (push) exp_q.push_back(model(op, a, b));
        @(posedge clk); #1;
        start = 1'b0; md_op = 2'($urandom); SrcA = $urandom; SrcB = $urandom;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL timeout: got busy=%b after 60 cycles expected 0", busy);
        end
    endtask

    task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b, 1'b1);
        wait_idle();
    endtask

    initial begin
        @(posedge clk); #1;
        rst = 1'b0;
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);

        run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(OP_MULT,  32'hFFFF_FFFD, 32'd5);
        run(OP_DIV,   32'hFFFF_FFF9, 32'd2);
        run(OP_DIVU,  32'd100,       32'd0);
        run(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        run(OP_DIV,   32'hFFFF_FFFB, 32'd0);
        run(OP_DIV,   32'd7,         32'hFFFF_FFFE);
        run(OP_MULT,  32'h8000_0000, 32'h8000_0000);

        // start and mthi while busy are both ignored
        issue(OP_DIVU, 32'd10, 32'd3, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        start = 1'b1; md_op = OP_MULTU; SrcA = 32'd99; SrcB = 32'd77;
        mthi = 1'b1; wdata = 32'h0000_1234;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;
        wait_idle();

        // reset mid-operation aborts without a done pulse
        issue(OP_DIVU, 32'd50, 32'd7, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        check("busy_before_abort", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        repeat (40) @(negedge clk);

        // IDLE writes
        @(posedge clk); #1;
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hAAAA_0000;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        check("mt_both_hi", 64'(hi), 64'hAAAA_0000);
        check("mt_both_lo", 64'(lo), 64'hAAAA_0000);
        mtlo = 1'b1; wdata = 32'h0000_5555;
        @(posedge clk); #1;
        mtlo = 1'b0;
        check("mtlo_hi", 64'(hi), 64'hAAAA_0000);
        check("mtlo_lo", 64'(lo), 64'h0000_5555);
        check("mt_busy", 64'(busy), 64'd0);
        check("mt_done", 64'(done), 64'd0);

        // mthi together with an accepted start: written, then overwritten
        @(posedge clk); #1;
        start = 1'b1; md_op = OP_MULTU; SrcA = 32'd7; SrcB = 32'd9;
        mthi = 1'b1; wdata = 32'hDEAD_0001;
        exp_q.push_back(model(OP_MULTU, 32'd7, 32'd9));
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;
        check("mt_with_start_hi", 64'(hi), 64'hDEAD_0001);
        wait_idle();

        for (int n = 0; n < 40; n++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            int unsigned sel;
            op  = 2'($urandom_range(0, 3));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) b = 32'($urandom_range(1, 15));
            else if (sel == 2) b = 32'hFFFF_FFFF;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            run(op, a, b);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
